// File: rtl/cbd_coeff_streamer_if.sv
// Valid/ready bundle between the CBD sampler, the coefficient streamer and the NTT / poly-add datapath.
// The slave modport is the streamer's view; the master modport is the view of whatever surrounds it.
interface cbd_coeff_streamer_if #(
  parameter int N      = 256,
  parameter int CIN_W  = 4,
  parameter int COUT_W = 12,
  parameter int LANES  = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*CIN_W-1:0]      poly_in;
  logic [2:0]              in_id;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*COUT_W-1:0] out_coeff;
  logic [7:0]              out_index;
  logic                    out_last;
  logic [2:0]              out_id;

  modport slave (
    input  in_valid, poly_in, in_id, out_ready,
    output in_ready, out_valid, out_coeff, out_index, out_last, out_id
  );

  modport master (
    output in_valid, poly_in, in_id, out_ready,
    input  in_ready, out_valid, out_coeff, out_index, out_last, out_id
  );
endinterface

// File: rtl/cbd_coeff_streamer.sv
// Holds one packed CBD noise polynomial and streams its coefficients, reduced to canonical
// residues mod Q, in index order; a new polynomial can be taken on the last beat of the previous one.
module cbd_coeff_streamer #(
  parameter int N      = 256,
  parameter int CIN_W  = 4,
  parameter int COUT_W = 12,
  parameter int Q      = 3329,
  parameter int LANES  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  cbd_coeff_streamer_if.slave  bus,
  output logic                 busy,
  output logic                 err_range
);

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [N*CIN_W-1:0]      hold;
  logic [LANES*COUT_W-1:0] coeff_q;
  logic [7:0]              index_q;
  logic                    last_q;
  logic [2:0]              id_q;
  logic                    oor_q;

  logic                    xfer;
  logic                    capture;
  logic                    advance;
  logic [N*CIN_W-1:0]      src;
  logic [7:0]              base;
  logic [LANES*COUT_W-1:0] beat_coeff;
  logic                    beat_oor;

  // Negative coefficients wrap to Q + c; the sign extension to COUT_W makes the add modular.
  function automatic logic [COUT_W-1:0] to_residue(input logic [CIN_W-1:0] c);
    logic [COUT_W-1:0] cext;
    cext = {{(COUT_W-CIN_W){c[CIN_W-1]}}, c};
    return c[CIN_W-1] ? (COUT_W'(Q) + cext) : cext;
  endfunction

  function automatic logic out_of_range(input logic [CIN_W-1:0] c);
    int v;
    v = int'($signed(c));
    return (v > 2) || (v < -2);
  endfunction

  assign xfer = (state == STREAM) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    advance      = 1'b0;
    bus.in_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          capture    = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (last_q) begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) capture    = 1'b1;
            else              state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next beat comes from the incoming poly on a capture, otherwise from the held copy.
  always_comb begin
    src        = capture ? bus.poly_in : hold;
    base       = capture ? 8'd0 : (index_q + 8'(LANES));
    beat_coeff = '0;
    beat_oor   = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      logic [7:0] li;
      li = base + 8'(k);
      beat_coeff[k*COUT_W +: COUT_W] = to_residue(src[li*CIN_W +: CIN_W]);
      beat_oor = beat_oor | out_of_range(src[li*CIN_W +: CIN_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      coeff_q   <= '0;
      index_q   <= '0;
      last_q    <= 1'b0;
      id_q      <= '0;
      oor_q     <= 1'b0;
      err_range <= 1'b0;
    end else begin
      if (xfer && oor_q) err_range <= 1'b1;
      if (capture) begin
        hold <= bus.poly_in;
        id_q <= bus.in_id;
      end
      if (capture || advance) begin
        coeff_q <= beat_coeff;
        index_q <= base;
        last_q  <= (base == 8'(N - LANES));
        oor_q   <= beat_oor;
      end
    end
  end

  assign bus.out_valid = (state == STREAM);
  assign bus.out_coeff = coeff_q;
  assign bus.out_index = index_q;
  assign bus.out_last  = last_q;
  assign bus.out_id    = id_q;
  assign busy          = (state == STREAM);

endmodule

// File: tb/tb_cbd_coeff_streamer.sv
// Directed bench for cbd_coeff_streamer: a LANES=1 instance for the protocol corner cases and
// one instance per lane width (1, 2, 4) streaming a zero poly and a stalled patterned poly.
module tb_cbd_coeff_streamer;

  localparam int N = 256;

  logic clk;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int residue(input logic [3:0] c);
    int v;
    v = int'($signed(c));
    return (v < 0) ? (3329 + v) : v;
  endfunction

  // ---------------- directed instance, LANES = 1 ----------------
  cbd_coeff_streamer_if bus ();
  logic rst;
  logic busy;
  logic err_range;

  cbd_coeff_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_range (err_range)
  );

  // Presents a poly for one edge; the caller makes sure the block is ready to take it.
  task automatic applyStimulus(input logic [N*4-1:0] p, input logic [2:0] id);
    bus.poly_in  = p;
    bus.in_id    = id;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitIndex(input int target);
    int cyc;
    cyc = 0;
    while (bus.out_index != 8'(target) && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 600) checkOutput("wait_index", bus.out_index, target);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- per-lane-width instances ----------------
  for (genvar g = 0; g < 3; g++) begin : lane_cfg
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    cbd_coeff_streamer_if #(.LANES(L)) lb ();
    logic lrst;
    logic lbusy;
    logic lerr;
    logic done_g;

    cbd_coeff_streamer #(.LANES(L)) u (
      .clk       (clk),
      .rst       (lrst),
      .bus       (lb),
      .busy      (lbusy),
      .err_range (lerr)
    );

    initial begin
      logic [N*4-1:0] p;
      logic [63:0]    exp_v;
      logic           xfer;
      int             idx;
      int             cyc;
      done_g       = 1'b0;
      lrst         = 1'b1;
      lb.in_valid  = 1'b0;
      lb.out_ready = 1'b0;
      lb.poly_in   = '0;
      lb.in_id     = '0;
      repeat (2) @(posedge clk);
      #1;
      lrst = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = 0; i < N; i++) p[i*4 +: 4] = pass ? 4'((i % 5) - 2) : 4'h0;
        lb.poly_in  = p;
        lb.in_id    = 3'(pass + 3);
        lb.in_valid = 1'b1;
        @(posedge clk);
        #1;
        lb.in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < N && cyc < 3000) begin
          checkOutput("lane_valid", lb.out_valid, 1);
          if (!lb.out_valid) break;
          exp_v = '0;
          for (int k = 0; k < L; k++) exp_v[k*12 +: 12] = 12'(residue(p[(idx+k)*4 +: 4]));
          checkOutput("lane_index", lb.out_index, idx);
          checkOutput("lane_coeff", lb.out_coeff, exp_v);
          checkOutput("lane_last", lb.out_last, (idx == N - L));
          checkOutput("lane_id", lb.out_id, pass + 3);
          lb.out_ready = pass ? 1'($urandom_range(0, 1)) : 1'b1;
          xfer = lb.out_ready;
          @(posedge clk);
          #1;
          if (xfer) idx += L;
          cyc++;
        end
        checkOutput("lane_beats", idx, N);
        checkOutput("lane_idle", lb.out_valid, 0);
        lb.out_ready = 1'b0;
      end
      done_g = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [N*4-1:0] p;
    logic [N*4-1:0] pa;
    logic [N*4-1:0] pb;
    int exp2 [8];
    int cyc;
    checks = 0;
    errors = 0;
    exp2 = '{3327, 3328, 0, 1, 2, 0, 0, 0};
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.poly_in  = '0;
    bus.in_id    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    nextCycle();
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_range, 0);
    checkOutput("rst_index", bus.out_index, 0);
    checkOutput("rst_coeff", bus.out_coeff, 0);
    checkOutput("rst_last", bus.out_last, 0);
    checkOutput("rst_id", bus.out_id, 0);

    // small negative and positive coefficients
    p = '0;
    p[3:0] = 4'hE; p[7:4] = 4'hF; p[11:8] = 4'h0; p[15:12] = 4'h1; p[19:16] = 4'h2;
    bus.out_ready = 1'b1;
    applyStimulus(p, 3'd3);
    checkOutput("t2_valid", bus.out_valid, 1);
    checkOutput("t2_busy", busy, 1);
    checkOutput("t2_in_ready", bus.in_ready, 0);
    checkOutput("t2_id", bus.out_id, 3);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_index", bus.out_index, i);
      checkOutput("t2_coeff", bus.out_coeff, exp2[i]);
      nextCycle();
    end
    waitIndex(254);
    checkOutput("t2_last_254", bus.out_last, 0);
    nextCycle();
    checkOutput("t2_last_255", bus.out_last, 1);
    checkOutput("t2_in_ready_last", bus.in_ready, 1);
    nextCycle();
    checkOutput("t2_idle", bus.out_valid, 0);
    checkOutput("t2_err", err_range, 0);

    // out-of-range coefficients raise the sticky flag
    p = '0;
    p[43:40] = 4'h7;
    p[47:44] = 4'h8;
    applyStimulus(p, 3'd4);
    waitIndex(10);
    checkOutput("t5_coeff10", bus.out_coeff, 7);
    checkOutput("t5_err_before", err_range, 0);
    nextCycle();
    checkOutput("t5_index11", bus.out_index, 11);
    checkOutput("t5_coeff11", bus.out_coeff, 3321);
    checkOutput("t5_err_after", err_range, 1);
    waitIndex(255);
    nextCycle();
    checkOutput("t5_idle", bus.out_valid, 0);
    checkOutput("t5_err_sticky", err_range, 1);

    // back-to-back polys, B held on in_valid throughout A
    for (int i = 0; i < N; i++) begin
      pa[i*4 +: 4] = 4'h1;
      pb[i*4 +: 4] = 4'h2;
    end
    applyStimulus(pa, 3'd1);
    bus.poly_in  = pb;
    bus.in_id    = 3'd2;
    bus.in_valid = 1'b1;
    checkOutput("t4_a_id", bus.out_id, 1);
    checkOutput("t4_a_in_ready", bus.in_ready, 0);
    waitIndex(100);
    checkOutput("t4_a_coeff_mid", bus.out_coeff, 1);
    checkOutput("t4_a_id_mid", bus.out_id, 1);
    waitIndex(255);
    checkOutput("t4_a_last", bus.out_last, 1);
    checkOutput("t4_a_in_ready_last", bus.in_ready, 1);
    nextCycle();
    bus.in_valid = 1'b0;
    checkOutput("t4_b_valid", bus.out_valid, 1);
    checkOutput("t4_b_index", bus.out_index, 0);
    checkOutput("t4_b_id", bus.out_id, 2);
    checkOutput("t4_b_coeff", bus.out_coeff, 2);
    nextCycle();
    checkOutput("t4_b_index1", bus.out_index, 1);
    waitIndex(255);
    nextCycle();
    checkOutput("t4_idle", bus.out_valid, 0);

    // reset in the middle of a stream
    applyStimulus(pa, 3'd5);
    waitIndex(100);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("t6_valid", bus.out_valid, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_in_ready", bus.in_ready, 1);
    checkOutput("t6_err_cleared", err_range, 0);
    checkOutput("t6_index", bus.out_index, 0);
    applyStimulus('0, 3'd6);
    checkOutput("t6_new_valid", bus.out_valid, 1);
    checkOutput("t6_new_index", bus.out_index, 0);
    checkOutput("t6_new_id", bus.out_id, 6);
    checkOutput("t6_new_coeff", bus.out_coeff, 0);
    waitIndex(255);
    nextCycle();
    checkOutput("t6_idle", bus.out_valid, 0);

    cyc = 0;
    while (!(lane_cfg[0].done_g && lane_cfg[1].done_g && lane_cfg[2].done_g) && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput("lanes_done",
                {lane_cfg[2].done_g, lane_cfg[1].done_g, lane_cfg[0].done_g}, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
